polar_to_cartesian: RTL

- Iterative rotation-mode CORDIC; inverse of the arm-angle atan2 path.
- Takes a joint angle in the same signed Q3.10 radian format the angle-solver emits, plus a fixed-point radius.
- Produces cartesian x = r·cos(θ) and y = r·sin(θ).
- Used by forward kinematics to turn commanded/measured joint angles into end-effector coordinates for the position controller.

---
 rtl/polar_to_cartesian.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/polar_to_cartesian.sv
// polar_to_cartesian: iterative rotation-mode CORDIC turning (angle, radius) into x = r*cos, y = r*sin
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset; aborts any computation, clears x/y
//   enable     start request, accepted only when idle
//   angle      signed Q3.10 radians
//   radius     signed fixed point, FRAC_BITS fractional bits
//   x, y       result, same format as radius, saturated, held until next result
//   busy       high from the accepted start up to and including the DataReady cycle
//   DataReady  one-cycle pulse when x/y carry a new result
module polar_to_cartesian #(
    parameter int ITER      = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [12:0] angle,
    input  logic [31:0] radius,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        busy,
    output logic        DataReady
);
    if (ITER < 8 || ITER > 20 || FRAC_BITS < 0 || FRAC_BITS > 31) begin : g_bad_param
        $error("polar_to_cartesian: parameter out of range");
    end
    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DONE} state_t;
    state_t             state_q, state_d;
    logic signed [12:0] ang_q, ang_d;
    logic signed [31:0] rad_q, rad_d;
    logic signed [33:0] xi_q, xi_d, yi_q, yi_d;
    logic signed [19:0] z_q, z_d;
    logic        [4:0]  i_q, i_d;
    logic        [31:0] x_q, x_d, y_q, y_d;
    logic               busy_q, busy_d, dr_q, dr_d;
    // atan(2^-i) in Q4.16, rounded to nearest
    function automatic logic signed [19:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    return 20'sd51472;
            5'd1:    return 20'sd30386;
            5'd2:    return 20'sd16055;
            5'd3:    return 20'sd8150;
            5'd4:    return 20'sd4091;
            5'd5:    return 20'sd2047;
            5'd6:    return 20'sd1024;
            5'd7:    return 20'sd512;
            5'd8:    return 20'sd256;
            5'd9:    return 20'sd128;
            5'd10:   return 20'sd64;
            5'd11:   return 20'sd32;
            5'd12:   return 20'sd16;
            5'd13:   return 20'sd8;
            5'd14:   return 20'sd4;
            5'd15:   return 20'sd2;
            5'd16:   return 20'sd1;
            5'd17:   return 20'sd1;
            default: return 20'sd0;
        endcase
    endfunction
    // Clamp the 34-bit internal value to the signed 32-bit output range
    function automatic logic [31:0] sat(input logic signed [33:0] v);
        return (v[33:31] == 3'b000 || v[33:31] == 3'b111) ? v[31:0] :
               v[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction
    logic signed [13:0] a_ext, wrap, fold;
    logic               neg;
    logic signed [32:0] r_ext;
    logic signed [49:0] prod, prod_sh;
    logic signed [33:0] x0, xs, ys, xr, yr;
    logic signed [19:0] z0, at, zr;
    logic               d;
    always_comb begin
        a_ext   = ang_q;
        // Bring the angle into [-pi, pi], then into [-pi/2, pi/2] by rotating
        // half a turn and flipping the start vector
        wrap    = (a_ext > 14'sd3217) ? a_ext - 14'sd6434 :
                  (a_ext < -14'sd3217) ? a_ext + 14'sd6434 : a_ext;
        neg     = (wrap > 14'sd1608) || (wrap < -14'sd1608);
        fold    = (wrap > 14'sd1608) ? wrap - 14'sd3217 :
                  (wrap < -14'sd1608) ? wrap + 14'sd3217 : wrap;
        z0      = {fold, 6'b0};
        r_ext   = neg ? -$signed({rad_q[31], rad_q}) : $signed({rad_q[31], rad_q});
        // Pre-scale by the CORDIC gain 1/K so no post-correction is needed
        prod    = r_ext * 50'sd39797;
        prod_sh = prod >>> 16;
        x0      = prod_sh[33:0];
        d       = ~z_q[19];
        xs      = xi_q >>> i_q;
        ys      = yi_q >>> i_q;
        at      = atan_lut(i_q);
        xr      = d ? xi_q - ys : xi_q + ys;
        yr      = d ? yi_q + xs : yi_q - xs;
        zr      = d ? z_q - at : z_q + at;
    end
    always_comb begin
        state_d = state_q;
        ang_d   = ang_q;
        rad_d   = rad_q;
        xi_d    = xi_q;
        yi_d    = yi_q;
        z_d     = z_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        dr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // The DataReady cycle is still part of the previous job
                if (enable && !dr_q) begin
                    ang_d   = angle;
                    rad_d   = radius;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                xi_d    = x0;
                yi_d    = '0;
                z_d     = z0;
                i_d     = '0;
                state_d = ROTATE;
            end
            ROTATE: begin
                xi_d    = xr;
                yi_d    = yr;
                z_d     = zr;
                i_d     = i_q + 5'd1;
                state_d = (i_q == 5'(ITER - 1)) ? DONE : ROTATE;
            end
            DONE: begin
                x_d     = sat(xi_q);
                y_d     = sat(yi_q);
                dr_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ang_q   <= '0;
            rad_q   <= '0;
            xi_q    <= '0;
            yi_q    <= '0;
            z_q     <= '0;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            dr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            rad_q   <= rad_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
            z_q     <= z_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            dr_q    <= dr_d;
        end
    end
    assign x         = x_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign DataReady = dr_q;
endmodule
